// File: rtl/radiant_trig_pkg.sv
// Shared types and helpers for the RADIANT multi-channel trigger oneshot.
// Optional feature macro used by the block: RADIANT_TRIG_POLARITY_EN.
package radiant_trig_pkg;

  // Per-channel oneshot state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2,
    STUCK   = 2'd3
  } trig_state_e;

  // Width of a counter that must hold values 0..stuck_cycles.
  function automatic int stuck_cnt_width(input int stuck_cycles);
    return $clog2(stuck_cycles + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/radiant_trig_oneshot_multi_if.sv
// Bus interface of radiant_trig_oneshot_multi: comparator samples, config and
// trigger outputs. With RADIANT_TRIG_POLARITY_EN defined, a per-channel input
// polarity vector pol_i is added.
// The block has no handshake: every input is sampled on each clock edge and
// every output is valid on every cycle (an implicit valid=1, ready=1 stream).
// state_dbg packs the 2-bit FSM state of channel c at [2c+1:2c].
interface radiant_trig_oneshot_multi_if #(
  parameter int NCH          = 24,
  parameter int WIDTH_BITS   = 4,
  parameter int HOLDOFF_BITS = 8
);
  logic [2*NCH-1:0]      din_i;
  logic [NCH-1:0]        enable_i;
  logic [WIDTH_BITS-1:0] width_i;
  logic [HOLDOFF_BITS-1:0] holdoff_i;
`ifdef RADIANT_TRIG_POLARITY_EN
  logic [NCH-1:0]        pol_i;
`endif
  logic [NCH-1:0]        trig_o;
  logic                  trig_or_o;
  logic [NCH-1:0]        scal_o;
  logic [NCH-1:0]        stuck_o;
  logic [2*NCH-1:0]      state_dbg;

`ifdef RADIANT_TRIG_POLARITY_EN
  modport master (output din_i, enable_i, width_i, holdoff_i, pol_i,
                  input  trig_o, trig_or_o, scal_o, stuck_o, state_dbg);
  modport slave  (input  din_i, enable_i, width_i, holdoff_i, pol_i,
                  output trig_o, trig_or_o, scal_o, stuck_o, state_dbg);
`else
  modport master (output din_i, enable_i, width_i, holdoff_i,
                  input  trig_o, trig_or_o, scal_o, stuck_o, state_dbg);
  modport slave  (input  din_i, enable_i, width_i, holdoff_i,
                  output trig_o, trig_or_o, scal_o, stuck_o, state_dbg);
`endif
endinterface

// File: rtl/radiant_trig_oneshot_ch.sv
// One trigger channel: DDR pair OR, two-stage input pipe, rising-edge detect,
// programmable pulse + holdoff FSM and stuck-high detection.
// Optional feature macro: RADIANT_TRIG_POLARITY_EN (adds pol_i inversion).
module radiant_trig_oneshot_ch
  import radiant_trig_pkg::*;
#(
  parameter int WIDTH_BITS   = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              din_i,
`ifdef RADIANT_TRIG_POLARITY_EN
  input  logic                    pol_i,
`endif
  input  logic                    enable_i,
  input  logic [WIDTH_BITS-1:0]   width_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic                    trig_o,
  output logic                    scal_o,
  output logic                    stuck_o,
  output logic [1:0]              state_o
);

  localparam int CW  = max_int(WIDTH_BITS, HOLDOFF_BITS);
  localparam int SCW = stuck_cnt_width(STUCK_CYCLES);
  localparam logic [SCW-1:0] STUCK_MAX  = SCW'(STUCK_CYCLES);
  localparam logic [SCW-1:0] STUCK_LAST = SCW'(STUCK_CYCLES - 1);

  logic lvl, in_q, in_d, edge_det, stuck_hit, accept, accept_q;
  logic [SCW-1:0] stuck_cnt_q;
  trig_state_e state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [HOLDOFF_BITS-1:0] ho_q, ho_n;

`ifdef RADIANT_TRIG_POLARITY_EN
  assign lvl = (|din_i) ^ pol_i;
`else
  assign lvl = |din_i;
`endif

  // Input pipe: in_q is the channel level, in_d its one-cycle-old copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_q <= 1'b0;
      in_d <= 1'b0;
    end else begin
      in_q <= lvl;
      in_d <= in_q;
    end
  end

  assign edge_det = in_q & ~in_d & enable_i;

  // Consecutive-high counter, saturating at STUCK_CYCLES, cleared by any low cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      stuck_cnt_q <= '0;
    else if (!in_q)                 stuck_cnt_q <= '0;
    else if (stuck_cnt_q != STUCK_MAX) stuck_cnt_q <= stuck_cnt_q + SCW'(1);
  end

  // This cycle is the STUCK_CYCLES-th consecutive high cycle.
  assign stuck_hit = in_q && (stuck_cnt_q == STUCK_LAST);

  // FSM state, shared pulse/holdoff down-counter and latched holdoff.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ho_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ho_q    <= ho_n;
    end
  end

  // Next state: stuck detection overrides every other transition.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ho_n    = ho_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          accept  = 1'b1;
          state_n = PULSE;
          cnt_n   = (width_i == '0) ? CW'(1) : CW'(width_i);
          ho_n    = holdoff_i;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(1)) begin
          if (ho_q != '0) begin
            state_n = HOLDOFF;
            cnt_n   = CW'(ho_q);
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CW'(1)) state_n = IDLE;
        else                 cnt_n   = cnt_q - CW'(1);
      end
      STUCK: begin
        if (!in_q) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (stuck_hit) begin
      state_n = STUCK;
      accept  = 1'b0;
    end
  end

  // Registered outputs: one cycle behind the state so din->trig is two edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      accept_q <= 1'b0;
      trig_o   <= 1'b0;
      scal_o   <= 1'b0;
      stuck_o  <= 1'b0;
    end else begin
      accept_q <= accept;
      trig_o   <= (state_q == PULSE);
      scal_o   <= accept_q || (state_q == STUCK);
      stuck_o  <= (state_q == STUCK);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/radiant_trig_oneshot_multi.sv
// RADIANT multi-channel trigger oneshot: NCH independent channels plus a
// registered OR of all channel triggers.
// Optional feature macro: RADIANT_TRIG_POLARITY_EN (per-channel pol_i).
module radiant_trig_oneshot_multi #(
  parameter int NCH          = 24,
  parameter int WIDTH_BITS   = 4,
  parameter int HOLDOFF_BITS = 8,
  parameter int STUCK_CYCLES = 1024
) (
  input logic clk_i,
  input logic rst_i,
  radiant_trig_oneshot_multi_if.slave bus
);

  logic [NCH-1:0]   trig_v, scal_v, stuck_v;
  logic [2*NCH-1:0] state_v;
  logic             trig_or_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    radiant_trig_oneshot_ch #(
      .WIDTH_BITS  (WIDTH_BITS),
      .HOLDOFF_BITS(HOLDOFF_BITS),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .din_i    (bus.din_i[2*c+1:2*c]),
`ifdef RADIANT_TRIG_POLARITY_EN
      .pol_i    (bus.pol_i[c]),
`endif
      .enable_i (bus.enable_i[c]),
      .width_i  (bus.width_i),
      .holdoff_i(bus.holdoff_i),
      .trig_o   (trig_v[c]),
      .scal_o   (scal_v[c]),
      .stuck_o  (stuck_v[c]),
      .state_o  (state_v[2*c+1:2*c])
    );
  end

  // Registered OR of all channel triggers for the trigger-logic stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) trig_or_q <= 1'b0;
    else       trig_or_q <= |trig_v;
  end

  assign bus.trig_o    = trig_v;
  assign bus.scal_o    = scal_v;
  assign bus.stuck_o   = stuck_v;
  assign bus.trig_or_o = trig_or_q;
  assign bus.state_dbg = state_v;

endmodule

// File: doc/radiant_trig_oneshot_multi.md
Name: radiant_trig_oneshot_multi

Overview:
- Multi-channel, parametrised trigger oneshot for the RADIANT trigger path.
- Takes per-channel DDR-sampled comparator pairs from upstream IDDRs in the fast trigger domain.
- Per channel: rising-edge detect, programmable-width output pulse, programmable holdoff, and stuck-high detection with masking.
- Produces per-channel triggers, per-channel scaler strobes (held high while stuck), a stuck status vector and an OR of all triggers for the trigger-logic stage.

Parameters:
- NCH, 24, number of channels.
- WIDTH_BITS, 4, width of pulse-width config; pulse length 1..2^WIDTH_BITS-1 cycles.
- HOLDOFF_BITS, 8, width of holdoff config; holdoff 0..2^HOLDOFF_BITS-1 cycles.
- STUCK_CYCLES, 1024, consecutive high cycles that declare a channel stuck (>=2).

Ports:
- clk_i  in  1  fast trigger clock; sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- din_i  in  2*NCH  DDR sample pairs; bits [2c+1:2c] belong to channel c.
- enable_i  in  NCH  per-channel trigger enable.
- width_i  in  WIDTH_BITS  pulse length in cycles; common to all channels.
- holdoff_i  in  HOLDOFF_BITS  dead cycles after a pulse; common to all channels.
- trig_o  out  NCH  per-channel oneshot output.
- trig_or_o  out  1  registered OR of trig_o.
- scal_o  out  NCH  1-cycle strobe per accepted edge; held high while stuck.
- stuck_o  out  NCH  channel currently stuck.

Behaviour:
- Reset (async, active-high) clears all state; every output is 0 and every channel is in IDLE.
- Input stage per channel:
  - lvl = OR of the channel's two DDR bits, registered to in_q; in_q is delayed once more to in_d.
  - edge = in_q & ~in_d & enable_i[c].
- Per-channel FSM: IDLE, PULSE, HOLDOFF, STUCK.
  - IDLE: on edge -> PULSE; latch width_i (0 treated as 1) and holdoff_i into a counter and a shadow register.
  - PULSE: trig_o[c]=1; lasts exactly the latched width.
    - On expiry -> HOLDOFF if latched holdoff != 0, else -> IDLE.
  - HOLDOFF: lasts the latched holdoff cycles, then -> IDLE.
  - Edges arriving in PULSE/HOLDOFF are dropped, with no scaler strobe.
  - An edge is not detected in the cycle IDLE is re-entered unless in_q rose that cycle.
- Latency: din_i sampled at clock edge n -> trig_o[c] and scal_o[c] high after edge n+2; trig_or_o one cycle later.
- scal_o[c]: 1-cycle pulse coincident with the first trig_o cycle of each accepted edge.
- Stuck detection:
  - Counter counts consecutive cycles of in_q=1 and saturates at STUCK_CYCLES; it clears on any cycle with in_q=0.
  - On reaching STUCK_CYCLES, from any state -> STUCK. This truncates trig_o the next cycle and sets stuck_o[c]=1 and scal_o[c]=1 continuously.
  - STUCK -> IDLE on the first cycle with in_q=0; stuck_o and scal_o drop the following cycle.
  - STUCK applies regardless of enable_i.
- Config changes mid-pulse have no effect until the next accepted edge.
- Deasserting enable_i mid-pulse lets the pulse and holdoff complete.
- Channels are fully independent; simultaneous edges on all channels all fire.
- Reset asserted mid-pulse drops trig_o immediately (asynchronously).

Optional Feature:
- Macro RADIANT_TRIG_POLARITY_EN.
- Defined: adds input port pol_i[NCH-1:0]; lvl for channel c is inverted when pol_i[c]=1, applied before in_q. Stuck detection applies to the post-inversion level.
- Undefined: no pol_i port; all channels are active-high.

Decomposition:
- Package radiant_trig_pkg holds:
  - the state enum typedef (IDLE, PULSE, HOLDOFF, STUCK);
  - a localparam function computing the stuck counter width as clog2(STUCK_CYCLES+1).
- Sub-module radiant_trig_oneshot_ch implements one channel: input regs, FSM, counters.
- The top generates NCH instances and registers trig_or_o.

Test Plan:
- NCH=4, width_i=3, holdoff_i=5; din pair 2'b01 for 1 cycle on ch0 -> trig_o[0] high exactly 3 cycles starting at edge n+2; scal_o[0] 1 cycle; trig_or_o follows 1 cycle later.
- Same config; second ch0 rising edge 4 cycles after the first (inside holdoff) -> no trig_o, no scal_o; an edge 10 cycles after the first -> fires.
- width_i=0, holdoff_i=0; ch1 toggles high/low every 2 cycles -> trig_o[1] 1-cycle pulses every 4 cycles; scal count matches edge count.
- STUCK_CYCLES=16; ch2 held high 40 cycles -> trig_o[2] pulse then low; stuck_o[2] and scal_o[2] high from cycle 16 of in_q high; both drop 1 cycle after the input falls; next rising edge triggers normally.
- enable_i[3]=0 with edges on ch3 -> no trig/scal; enable_i deasserted mid-pulse on ch0 -> pulse completes at full width; rst_i asserted mid-pulse -> all outputs 0 immediately.
- With RADIANT_TRIG_POLARITY_EN and pol_i[0]=1, ch0 din idles 2'b11 then drops to 2'b00 -> trigger fires; idling 2'b00 for STUCK_CYCLES -> stuck_o[0]=1.
